// File: rtl/fb_arbiter_if.sv
// -----------------------------------------------------------------------------
// fb_arbiter_if
// Bundles the frame-buffer arbiter's requester, read-return and RAM-side
// signals so that the arbiter and its environment connect through one port.
//
// Port summary (signal groups):
//   display fetch : disp_req, disp_addr, disp_urgent -> disp_gnt, disp_rvalid
//   Sobel engine  : sob_req, sob_addr, sob_we, sob_wdata -> sob_gnt, sob_rvalid
//   read return   : rdata (pass-through of ram_rdata)
//   RAM side      : ram_en, ram_we, ram_addr, ram_wdata -> ram_rdata
//
// Modports:
//   slave  : the arbiter's view.
//   master : the environment's view (requesters plus the RAM).
// -----------------------------------------------------------------------------
interface fb_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
);
    // Display fetch (read-only requester)
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_urgent;
    logic              disp_gnt;
    logic              disp_rvalid;

    // Sobel engine (read/write requester)
    logic              sob_req;
    logic [ADDR_W-1:0] sob_addr;
    logic              sob_we;
    logic [DATA_W-1:0] sob_wdata;
    logic              sob_gnt;
    logic              sob_rvalid;

    // Shared read-data return
    logic [DATA_W-1:0] rdata;

    // Single-port frame-buffer RAM
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  disp_req, disp_addr, disp_urgent,
        output disp_gnt, disp_rvalid,
        input  sob_req, sob_addr, sob_we, sob_wdata,
        output sob_gnt, sob_rvalid,
        output rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output disp_req, disp_addr, disp_urgent,
        input  disp_gnt, disp_rvalid,
        output sob_req, sob_addr, sob_we, sob_wdata,
        input  sob_gnt, sob_rvalid,
        input  rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/fb_arbiter.sv
// -----------------------------------------------------------------------------
// fb_arbiter
// Shares the single-port frame-buffer RAM between the VGA display fetch
// (read-only, priority) and the Sobel engine (read/write).
//
// The display normally wins. When the display has won STARVE_MAX times in a row
// while Sobel was waiting, Sobel gets the next slot. disp_urgent overrides that
// guard, so a nearly empty line FIFO is never starved by Sobel.
//
// Ports:
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : fb_arbiter_if.slave
//          - grants are combinational from the requests and starve_cnt_r
//          - ram_* are registered one cycle after the grant
//          - disp_rvalid/sob_rvalid follow the grant by 1+RAM_LAT cycles
//          - rdata is ram_rdata passed straight through
// -----------------------------------------------------------------------------
module fb_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 4,
    parameter int RAM_LAT    = 1
) (
    input  logic          clk,
    input  logic          rst,
    fb_arbiter_if.slave   bus
);

    // Stage k of the tag pipeline matches the RAM cycle that is k cycles past
    // the enable. The last stage therefore lines up with valid ram_rdata.
    localparam int         TAG_STAGES = RAM_LAT + 1;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic                        disp_gnt_s;
    logic                        sob_gnt_s;
    logic [3:0]                  starve_cnt_r;
    logic [3:0]                  starve_cnt_nxt_s;
    logic [TAG_STAGES-1:0][1:0]  tag_r;          // {disp, sob} per issued access
    logic [1:0]                  tag_in_s;
    logic                        ram_en_r;
    logic                        ram_we_r;
    logic [ADDR_W-1:0]           ram_addr_r;
    logic [DATA_W-1:0]           ram_wdata_r;

    // Grant decision: at most one grant per cycle, none while in reset.
    always_comb begin
        disp_gnt_s = 1'b0;
        sob_gnt_s  = 1'b0;
        if (rst) begin
            disp_gnt_s = 1'b0;
            sob_gnt_s  = 1'b0;
        end else if (bus.disp_req && bus.sob_req) begin
            if (bus.disp_urgent) begin
                disp_gnt_s = 1'b1;
            end else if (starve_cnt_r == STARVE_LIM) begin
                sob_gnt_s = 1'b1;
            end else begin
                disp_gnt_s = 1'b1;
            end
        end else if (bus.disp_req) begin
            disp_gnt_s = 1'b1;
        end else if (bus.sob_req) begin
            sob_gnt_s = 1'b1;
        end else begin
            disp_gnt_s = 1'b0;
            sob_gnt_s  = 1'b0;
        end
    end

    // Starvation counter next state. The count saturates at the limit, so it
    // holds there while urgent display wins keep Sobel waiting.
    always_comb begin
        starve_cnt_nxt_s = starve_cnt_r;
        if (!bus.sob_req || sob_gnt_s) begin
            starve_cnt_nxt_s = 4'd0;
        end else if (disp_gnt_s && (starve_cnt_r != STARVE_LIM)) begin
            starve_cnt_nxt_s = starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_nxt_s = starve_cnt_r;
        end
    end

    // Tag for the access issued this cycle. Writes carry an empty tag, so no
    // rvalid ever follows a write.
    always_comb begin
        tag_in_s = 2'b00;
        if (disp_gnt_s) begin
            tag_in_s = 2'b10;
        end else if (sob_gnt_s && !bus.sob_we) begin
            tag_in_s = 2'b01;
        end else begin
            tag_in_s = 2'b00;
        end
    end

    // Registered RAM issue, starvation counter and read-tag pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_r <= 4'd0;
            ram_en_r     <= 1'b0;
            ram_we_r     <= 1'b0;
            ram_addr_r   <= '0;
            ram_wdata_r  <= '0;
            tag_r        <= '0;
        end else begin
            starve_cnt_r <= starve_cnt_nxt_s;
            if (disp_gnt_s) begin
                ram_en_r   <= 1'b1;
                ram_we_r   <= 1'b0;
                ram_addr_r <= bus.disp_addr;
            end else if (sob_gnt_s) begin
                ram_en_r    <= 1'b1;
                ram_we_r    <= bus.sob_we;
                ram_addr_r  <= bus.sob_addr;
                ram_wdata_r <= bus.sob_wdata;
            end else begin
                // Idle slot: address and write data hold their last values.
                ram_en_r <= 1'b0;
                ram_we_r <= 1'b0;
            end
            tag_r[0] <= tag_in_s;
            for (int i = 1; i < TAG_STAGES; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    assign bus.disp_gnt    = disp_gnt_s;
    assign bus.sob_gnt     = sob_gnt_s;
    assign bus.ram_en      = ram_en_r;
    assign bus.ram_we      = ram_we_r;
    assign bus.ram_addr    = ram_addr_r;
    assign bus.ram_wdata   = ram_wdata_r;
    assign bus.disp_rvalid = tag_r[TAG_STAGES-1][1];
    assign bus.sob_rvalid  = tag_r[TAG_STAGES-1][0];
    assign bus.rdata       = bus.ram_rdata;

endmodule

// File: tb/tb_fb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_arbiter
// Directed bench for fb_arbiter with a 1-cycle-latency RAM model.
// Inputs change at the falling edge. The combinational grants are checked #1
// later. Registered outputs are checked at the falling edge, before the new
// inputs are applied.
// -----------------------------------------------------------------------------
module tb_fb_arbiter;
    localparam int ADDR_W     = 17;
    localparam int DATA_W     = 8;
    localparam int STARVE_MAX = 4;

    logic clk;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;

    fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    fb_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .RAM_LAT(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The RAM contents are preloaded as addr[7:0] ^ 8'h3C.
    function automatic logic [7:0] init_val(input int a);
        return 8'(a) ^ 8'h3C;
    endfunction

    // RAM model: 1-cycle read latency, in-order accesses, reloaded during reset.
    logic [7:0] mem [0:1023];
    logic [7:0] ram_q;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
        end else if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr[9:0]] <= bus.ram_wdata;
            else            ram_q <= mem[bus.ram_addr[9:0]];
        end
    end
    assign bus.ram_rdata = ram_q;

    task automatic idle_inputs();
        bus.disp_req    = 1'b0;
        bus.disp_urgent = 1'b0;
        bus.sob_req     = 1'b0;
        bus.sob_we      = 1'b0;
    endtask

    task automatic drain();
        idle_inputs();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.disp_req = 1'b1; bus.disp_addr = 17'h00100; bus.disp_urgent = 1'b0;
        bus.sob_req = 1'b1; bus.sob_addr = 17'h00200; bus.sob_we = 1'b0; bus.sob_wdata = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if ({bus.disp_gnt, bus.sob_gnt, bus.ram_en, bus.ram_we, bus.disp_rvalid, bus.sob_rvalid} !== 6'b0) begin
                tests_failed++;
                $display("FAIL reset_outputs cyc=%0d got gnt=%b%b en=%b we=%b rv=%b%b expected all 0", i,
                         bus.disp_gnt, bus.sob_gnt, bus.ram_en, bus.ram_we, bus.disp_rvalid, bus.sob_rvalid);
            end
            tests_run++;
            if (bus.ram_addr !== 17'h0 || bus.ram_wdata !== 8'h00) begin
                tests_failed++;
                $display("FAIL reset_ram_bus got addr=%h wdata=%h expected 0", bus.ram_addr, bus.ram_wdata);
            end
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if ({bus.disp_gnt, bus.sob_gnt} !== 2'b10) begin
            tests_failed++;
            $display("FAIL reset_release_gnt got %b%b expected 10", bus.disp_gnt, bus.sob_gnt);
        end
        @(negedge clk);
        tests_run++;
        if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b0 || bus.ram_addr !== 17'h00100) begin
            tests_failed++;
            $display("FAIL reset_release_issue got en=%b we=%b addr=%h expected 1 0 00100",
                     bus.ram_en, bus.ram_we, bus.ram_addr);
        end
        drain();
    endtask

    task automatic test_disp_only();
        logic [7:0] exp_d [4];
        exp_d = '{8'h2C, 8'h2D, 8'h2E, 8'h2F};
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            tests_run++;
            if (bus.ram_en !== ((k >= 1) && (k <= 4)) || bus.ram_we !== 1'b0) begin
                tests_failed++;
                $display("FAIL disp_ram_en k=%0d got en=%b we=%b", k, bus.ram_en, bus.ram_we);
            end
            if (k >= 1) begin
                tests_run++;
                if (bus.ram_addr !== (17'h00010 + 17'((k > 4) ? 3 : k - 1))) begin
                    tests_failed++;
                    $display("FAIL disp_ram_addr k=%0d got %h", k, bus.ram_addr);
                end
            end
            tests_run++;
            if (bus.disp_rvalid !== ((k >= 2) && (k <= 5)) || bus.sob_rvalid !== 1'b0) begin
                tests_failed++;
                $display("FAIL disp_rvalid k=%0d got d=%b s=%b", k, bus.disp_rvalid, bus.sob_rvalid);
            end
            if (k >= 2 && k <= 5) begin
                tests_run++;
                if (bus.rdata !== exp_d[k-2]) begin
                    tests_failed++;
                    $display("FAIL disp_rdata k=%0d got %h expected %h", k, bus.rdata, exp_d[k-2]);
                end
            end
            bus.disp_req  = (k < 4);
            bus.disp_addr = 17'h00010 + 17'(k);
            bus.sob_req   = 1'b0;
            #1;
            tests_run++;
            if (bus.disp_gnt !== (k < 4) || bus.sob_gnt !== 1'b0) begin
                tests_failed++;
                $display("FAIL disp_gnt k=%0d got %b%b", k, bus.disp_gnt, bus.sob_gnt);
            end
        end
        drain();
    endtask

    task automatic test_starvation();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            // Sobel wins on cycles 4 and 9; its read data appears two cycles later.
            tests_run++;
            if (bus.sob_rvalid !== (k == 6) || bus.disp_rvalid !== (k >= 2 && k != 6)) begin
                tests_failed++;
                $display("FAIL starve_rvalid k=%0d got d=%b s=%b", k, bus.disp_rvalid, bus.sob_rvalid);
            end
            if (k >= 2) begin
                tests_run++;
                if (bus.rdata !== ((k == 6) ? 8'h7C : 8'h0C)) begin
                    tests_failed++;
                    $display("FAIL starve_rdata k=%0d got %h", k, bus.rdata);
                end
            end
            bus.disp_req = 1'b1; bus.disp_addr = 17'h00030;
            bus.sob_req = 1'b1; bus.sob_addr = 17'h00040; bus.sob_we = 1'b0;
            #1;
            tests_run++;
            if (dut.starve_cnt_r !== 4'(k % 5)) begin
                tests_failed++;
                $display("FAIL starve_cnt k=%0d got %0d expected %0d", k, dut.starve_cnt_r, k % 5);
            end
            tests_run++;
            if ({bus.disp_gnt, bus.sob_gnt} !== ((k % 5 == 4) ? 2'b01 : 2'b10)) begin
                tests_failed++;
                $display("FAIL starve_gnt k=%0d got %b%b", k, bus.disp_gnt, bus.sob_gnt);
            end
        end
        drain();
    endtask

    task automatic test_urgent();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            bus.disp_req = 1'b1; bus.disp_addr = 17'h00050;
            bus.sob_req = 1'b1; bus.sob_addr = 17'h00060; bus.sob_we = 1'b0;
            bus.disp_urgent = (k >= 4) && (k < 14);
            #1;
            tests_run++;
            if (dut.starve_cnt_r !== ((k <= 3) ? 4'(k) : ((k <= 14) ? 4'd4 : 4'd0))) begin
                tests_failed++;
                $display("FAIL urgent_cnt k=%0d got %0d", k, dut.starve_cnt_r);
            end
            tests_run++;
            if ({bus.disp_gnt, bus.sob_gnt} !== ((k == 14) ? 2'b01 : 2'b10)) begin
                tests_failed++;
                $display("FAIL urgent_gnt k=%0d got %b%b", k, bus.disp_gnt, bus.sob_gnt);
            end
        end
        drain();
    endtask

    task automatic test_write_read();
        @(negedge clk);
        bus.sob_req = 1'b1; bus.sob_we = 1'b1; bus.sob_addr = 17'h01234; bus.sob_wdata = 8'hA5;
        #1;
        tests_run++;
        if ({bus.disp_gnt, bus.sob_gnt} !== 2'b01) begin
            tests_failed++;
            $display("FAIL wr_gnt got %b%b expected 01", bus.disp_gnt, bus.sob_gnt);
        end
        @(negedge clk);
        tests_run++;
        if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_addr !== 17'h01234 || bus.ram_wdata !== 8'hA5) begin
            tests_failed++;
            $display("FAIL wr_issue got en=%b we=%b addr=%h wd=%h", bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata);
        end
        bus.sob_we = 1'b0;
        #1;
        tests_run++;
        if (bus.sob_gnt !== 1'b1) begin
            tests_failed++;
            $display("FAIL rd_gnt got %b expected 1", bus.sob_gnt);
        end
        @(negedge clk);
        tests_run++;
        if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b0 || bus.sob_rvalid !== 1'b0 || bus.disp_rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd_issue got en=%b we=%b srv=%b drv=%b", bus.ram_en, bus.ram_we, bus.sob_rvalid, bus.disp_rvalid);
        end
        idle_inputs();
        @(negedge clk);
        tests_run++;
        if (bus.sob_rvalid !== 1'b1 || bus.rdata !== 8'hA5) begin
            tests_failed++;
            $display("FAIL rd_return got rv=%b data=%h expected 1 a5", bus.sob_rvalid, bus.rdata);
        end
        @(negedge clk);
        tests_run++;
        if (bus.sob_rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd_single got rv=%b expected 0", bus.sob_rvalid);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.sob_req = 1'b1; bus.sob_we = 1'b1; bus.sob_addr = 17'h00777; bus.sob_wdata = 8'h5A;
        @(negedge clk);
        bus.sob_req = 1'b0; bus.sob_we = 1'b0;
        bus.disp_req = 1'b1; bus.disp_addr = 17'h00777;
        #1;
        tests_run++;
        if ({bus.disp_gnt, bus.sob_gnt} !== 2'b10) begin
            tests_failed++;
            $display("FAIL b2b_gnt got %b%b expected 10", bus.disp_gnt, bus.sob_gnt);
        end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        tests_run++;
        if (bus.disp_rvalid !== 1'b1 || bus.sob_rvalid !== 1'b0 || bus.rdata !== 8'h5A) begin
            tests_failed++;
            $display("FAIL b2b_raw got drv=%b srv=%b data=%h expected 1 0 5a", bus.disp_rvalid, bus.sob_rvalid, bus.rdata);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.disp_req = 1'b1; bus.disp_addr = 17'h00020;
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if ({bus.disp_gnt, bus.sob_gnt} !== 2'b00) begin
            tests_failed++;
            $display("FAIL rstmid_gnt got %b%b expected 00", bus.disp_gnt, bus.sob_gnt);
        end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        tests_run++;
        if (bus.disp_rvalid !== 1'b0 || bus.ram_en !== 1'b0 || bus.ram_addr !== 17'h0 || dut.starve_cnt_r !== 4'd0) begin
            tests_failed++;
            $display("FAIL rstmid_clear got drv=%b en=%b addr=%h cnt=%0d", bus.disp_rvalid, bus.ram_en, bus.ram_addr, dut.starve_cnt_r);
        end
        @(negedge clk);
        tests_run++;
        if (bus.disp_rvalid !== 1'b0 || bus.sob_rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_norv got drv=%b srv=%b expected 0 0", bus.disp_rvalid, bus.sob_rvalid);
        end
    endtask

    initial begin
        test_reset();
        test_disp_only();
        test_starvation();
        test_urgent();
        test_write_read();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
